// File: rtl/pseg_pkg.sv
// Shared constants, operand slot type and wait-count helper for the pipeline segment.
package pseg_pkg;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;

  typedef struct packed {
    logic                 ren;
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      val;
  } op_slot_t;

  // Saturating decrement; callers narrow the result to their wait-field width.
  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction
endpackage

// File: rtl/pseg_bypass_mux.sv
// Writeback snoop for one operand slot: returns the operand value corrected by the
// highest-priority (lowest-numbered) matching writeback port.
module pseg_bypass_mux
  import pseg_pkg::*;
#(
  parameter int unsigned NUM_WB = 2
) (
  input  op_slot_t                    op,
  input  logic [NUM_WB-1:0]           wb_wen,
  input  logic [NUM_WB*REG_IDX_W-1:0] wb_wreg,
  input  logic [NUM_WB*XLEN-1:0]      wb_wdata,
  output logic [XLEN-1:0]             val_c
);

  // Scan from the lowest-priority port so port 0 is applied last and wins.
  always_comb begin
    val_c = op.val;
    if (op.ren && (op.idx != '0)) begin
      for (int j = int'(NUM_WB) - 1; j >= 0; j--) begin
        if (wb_wen[j] && (wb_wreg[j*REG_IDX_W +: REG_IDX_W] == op.idx)) begin
          val_c = wb_wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/pipe_seg_bypass.sv
// Valid/ready pipeline segment carrying payload, bypass-corrected operands and a wait countdown.
// Optional macro PSEG_SKID_EN adds a second (skid) entry and a registered in_ready.
module pipe_seg_bypass
  import pseg_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned NUM_OPS   = 2,
  parameter int unsigned NUM_WB    = 2,
  parameter int unsigned WAIT_W    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PAYLOAD_W-1:0]          in_payload,
  input  logic [NUM_OPS-1:0]            in_op_ren,
  input  logic [NUM_OPS*REG_IDX_W-1:0]  in_op_idx,
  input  logic [NUM_OPS*XLEN-1:0]       in_op_val,
  input  logic [WAIT_W-1:0]             in_wait,
  input  logic [NUM_WB-1:0]             wb_wen,
  input  logic [NUM_WB*REG_IDX_W-1:0]   wb_wreg,
  input  logic [NUM_WB*XLEN-1:0]        wb_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PAYLOAD_W-1:0]          out_payload,
  output logic [NUM_OPS*REG_IDX_W-1:0]  out_op_idx,
  output logic [NUM_OPS*XLEN-1:0]       out_op_val,
  output logic [WAIT_W-1:0]             out_wait
);

`ifdef PSEG_SKID_EN
  localparam int unsigned NUM_ENT = 2;
`else
  localparam int unsigned NUM_ENT = 1;
`endif

  // Entry 0 is the main (output) entry; entry 1, when present, is the skid entry.
  logic [NUM_ENT-1:0]   ent_valid_q, ent_valid_d;
  logic [PAYLOAD_W-1:0] ent_payload_q [NUM_ENT];
  logic [PAYLOAD_W-1:0] ent_payload_d [NUM_ENT];
  op_slot_t             ent_op_q      [NUM_ENT][NUM_OPS];
  op_slot_t             ent_op_d      [NUM_ENT][NUM_OPS];
  op_slot_t             ent_op_upd_c  [NUM_ENT][NUM_OPS];
  logic [XLEN-1:0]      ent_byp_val_c [NUM_ENT][NUM_OPS];
  logic [WAIT_W-1:0]    ent_wait_q    [NUM_ENT];
  logic [WAIT_W-1:0]    ent_wait_d    [NUM_ENT];
  logic [WAIT_W-1:0]    ent_wait_upd_c[NUM_ENT];

  op_slot_t             in_op_raw_c   [NUM_OPS];
  op_slot_t             in_op_c       [NUM_OPS];
  logic [XLEN-1:0]      in_byp_val_c  [NUM_OPS];
  logic [WAIT_W-1:0]    in_wait_ld_c;
  logic                 accept_c;
  logic                 issue_c;

  // Incoming operands see same-cycle writebacks before they are captured.
  for (genvar k = 0; k < int'(NUM_OPS); k++) begin : g_in_op
    assign in_op_raw_c[k] = {in_op_ren[k], in_op_idx[k*REG_IDX_W +: REG_IDX_W],
                             in_op_val[k*XLEN +: XLEN]};
    pseg_bypass_mux #(.NUM_WB(NUM_WB)) u_byp (
      .op       (in_op_raw_c[k]),
      .wb_wen   (wb_wen),
      .wb_wreg  (wb_wreg),
      .wb_wdata (wb_wdata),
      .val_c    (in_byp_val_c[k])
    );
    assign in_op_c[k] = {in_op_ren[k], in_op_idx[k*REG_IDX_W +: REG_IDX_W], in_byp_val_c[k]};
  end

  assign in_wait_ld_c = WAIT_W'(sat_dec(32'(in_wait)));

  // Held entries are refreshed by writebacks and count down every cycle they stay.
  for (genvar e = 0; e < int'(NUM_ENT); e++) begin : g_ent
    for (genvar k = 0; k < int'(NUM_OPS); k++) begin : g_op
      pseg_bypass_mux #(.NUM_WB(NUM_WB)) u_byp (
        .op       (ent_op_q[e][k]),
        .wb_wen   (wb_wen),
        .wb_wreg  (wb_wreg),
        .wb_wdata (wb_wdata),
        .val_c    (ent_byp_val_c[e][k])
      );
      assign ent_op_upd_c[e][k] = {ent_op_q[e][k].ren, ent_op_q[e][k].idx, ent_byp_val_c[e][k]};
    end
    assign ent_wait_upd_c[e] = WAIT_W'(sat_dec(32'(ent_wait_q[e])));
  end

`ifdef PSEG_SKID_EN
  assign in_ready = !ent_valid_q[NUM_ENT-1];
`else
  assign in_ready = !ent_valid_q[0] || out_ready;
`endif

  assign accept_c = in_valid && in_ready;
  assign issue_c  = ent_valid_q[0] && out_ready;

  // Next-state: held update first, then flush > issue/accept movement.
  always_comb begin
    ent_valid_d   = ent_valid_q;
    ent_payload_d = ent_payload_q;
    ent_op_d      = ent_op_q;
    ent_wait_d    = ent_wait_q;
    for (int e = 0; e < int'(NUM_ENT); e++) begin
      if (ent_valid_q[e]) begin
        for (int k = 0; k < int'(NUM_OPS); k++) ent_op_d[e][k] = ent_op_upd_c[e][k];
        ent_wait_d[e] = ent_wait_upd_c[e];
      end
    end
    if (flush) begin
      ent_valid_d = '0;
      for (int e = 0; e < int'(NUM_ENT); e++) begin
        ent_payload_d[e] = '0;
        ent_wait_d[e]    = '0;
        for (int k = 0; k < int'(NUM_OPS); k++) ent_op_d[e][k] = '0;
      end
    end else begin
`ifdef PSEG_SKID_EN
      if (issue_c) begin
        if (ent_valid_q[1]) begin
          ent_valid_d[1]   = 1'b0;
          ent_payload_d[0] = ent_payload_q[1];
          ent_wait_d[0]    = ent_wait_upd_c[1];
          for (int k = 0; k < int'(NUM_OPS); k++) ent_op_d[0][k] = ent_op_upd_c[1][k];
        end else if (accept_c) begin
          ent_payload_d[0] = in_payload;
          ent_wait_d[0]    = in_wait_ld_c;
          for (int k = 0; k < int'(NUM_OPS); k++) ent_op_d[0][k] = in_op_c[k];
        end else begin
          ent_valid_d[0] = 1'b0;
        end
      end else if (accept_c) begin
        if (ent_valid_q[0]) begin
          ent_valid_d[1]   = 1'b1;
          ent_payload_d[1] = in_payload;
          ent_wait_d[1]    = in_wait_ld_c;
          for (int k = 0; k < int'(NUM_OPS); k++) ent_op_d[1][k] = in_op_c[k];
        end else begin
          ent_valid_d[0]   = 1'b1;
          ent_payload_d[0] = in_payload;
          ent_wait_d[0]    = in_wait_ld_c;
          for (int k = 0; k < int'(NUM_OPS); k++) ent_op_d[0][k] = in_op_c[k];
        end
      end
`else
      if (accept_c) begin
        ent_valid_d[0]   = 1'b1;
        ent_payload_d[0] = in_payload;
        ent_wait_d[0]    = in_wait_ld_c;
        for (int k = 0; k < int'(NUM_OPS); k++) ent_op_d[0][k] = in_op_c[k];
      end else if (issue_c) begin
        ent_valid_d[0] = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid_q <= '0;
      for (int e = 0; e < int'(NUM_ENT); e++) begin
        ent_payload_q[e] <= '0;
        ent_wait_q[e]    <= '0;
        for (int k = 0; k < int'(NUM_OPS); k++) ent_op_q[e][k] <= '0;
      end
    end else begin
      ent_valid_q <= ent_valid_d;
      for (int e = 0; e < int'(NUM_ENT); e++) begin
        ent_payload_q[e] <= ent_payload_d[e];
        ent_wait_q[e]    <= ent_wait_d[e];
        for (int k = 0; k < int'(NUM_OPS); k++) ent_op_q[e][k] <= ent_op_d[e][k];
      end
    end
  end

  assign out_valid   = ent_valid_q[0];
  assign out_payload = ent_payload_q[0];
  assign out_wait    = ent_wait_q[0];
  for (genvar k = 0; k < int'(NUM_OPS); k++) begin : g_out
    assign out_op_idx[k*REG_IDX_W +: REG_IDX_W] = ent_op_q[0][k].idx;
    assign out_op_val[k*XLEN +: XLEN]           = ent_op_q[0][k].val;
  end

endmodule

// File: tb/tb_pipe_seg_bypass.sv
// Scoreboard bench for pipe_seg_bypass: a queue model of held entries predicts every output.
module tb_pipe_seg_bypass;
  localparam int unsigned PAYLOAD_W = 64;
  localparam int unsigned NUM_OPS   = 2;
  localparam int unsigned NUM_WB    = 2;
  localparam int unsigned WAIT_W    = 2;

  logic                  clk;
  logic                  reset;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [PAYLOAD_W-1:0]  in_payload;
  logic [NUM_OPS-1:0]    in_op_ren;
  logic [NUM_OPS*5-1:0]  in_op_idx;
  logic [NUM_OPS*32-1:0] in_op_val;
  logic [WAIT_W-1:0]     in_wait;
  logic [NUM_WB-1:0]     wb_wen;
  logic [NUM_WB*5-1:0]   wb_wreg;
  logic [NUM_WB*32-1:0]  wb_wdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [PAYLOAD_W-1:0]  out_payload;
  logic [NUM_OPS*5-1:0]  out_op_idx;
  logic [NUM_OPS*32-1:0] out_op_val;
  logic [WAIT_W-1:0]     out_wait;

  pipe_seg_bypass #(
    .PAYLOAD_W(PAYLOAD_W), .NUM_OPS(NUM_OPS), .NUM_WB(NUM_WB), .WAIT_W(WAIT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_op_ren(in_op_ren), .in_op_idx(in_op_idx), .in_op_val(in_op_val), .in_wait(in_wait),
    .wb_wen(wb_wen), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_op_idx(out_op_idx), .out_op_val(out_op_val), .out_wait(out_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PAYLOAD_W-1:0]           payload;
    logic [NUM_OPS-1:0]             ren;
    logic [NUM_OPS-1:0][4:0]        idx;
    logic [NUM_OPS-1:0][31:0]       val;
    logic [WAIT_W-1:0]              wt;
  } ent_t;

  ent_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cleared = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] byp(input logic ren, input logic [4:0] idx, input logic [31:0] v);
    if (!ren || idx == 5'd0) return v;
    for (int j = 0; j < int'(NUM_WB); j++)
      if (wb_wen[j] && wb_wreg[j*5 +: 5] == idx) return wb_wdata[j*32 +: 32];
    return v;
  endfunction

  function automatic logic [WAIT_W-1:0] dec(input logic [WAIT_W-1:0] w);
    return (w == '0) ? '0 : w - WAIT_W'(1);
  endfunction

  // One clock: predict handshake and next state, then compare the DUT after the edge.
  task automatic step();
    bit   exp_rdy, acc, iss;
    ent_t e;
    #1;
`ifdef PSEG_SKID_EN
    exp_rdy = (exp_q.size() < 2);
`else
    exp_rdy = (exp_q.size() == 0) || out_ready;
`endif
    if (!reset) check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = in_valid && exp_rdy;
    iss = (exp_q.size() > 0) && out_ready;
    if (reset || flush) begin
      exp_q.delete();
      cleared = 1'b1;
    end else begin
      if (iss || acc) cleared = 1'b0;
      if (iss) void'(exp_q.pop_front());
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        for (int k = 0; k < int'(NUM_OPS); k++) e.val[k] = byp(e.ren[k], e.idx[k], e.val[k]);
        e.wt = dec(e.wt);
        exp_q[i] = e;
      end
      if (acc) begin
        e.payload = in_payload;
        e.ren     = in_op_ren;
        for (int k = 0; k < int'(NUM_OPS); k++) begin
          e.idx[k] = in_op_idx[k*5 +: 5];
          e.val[k] = byp(in_op_ren[k], in_op_idx[k*5 +: 5], in_op_val[k*32 +: 32]);
        end
        e.wt = dec(in_wait);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("out_valid", 64'(out_valid), 64'd0);
      if (cleared) begin
        check("clr_payload", 64'(out_payload), 64'd0);
        check("clr_op_val", 64'(out_op_val), 64'd0);
        check("clr_op_idx", 64'(out_op_idx), 64'd0);
        check("clr_wait", 64'(out_wait), 64'd0);
      end
    end else begin
      e = exp_q[0];
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_payload", 64'(out_payload), 64'(e.payload));
      check("out_op_idx", 64'(out_op_idx), 64'(e.idx));
      check("out_op_val", 64'(out_op_val), 64'(e.val));
      check("out_wait", 64'(out_wait), 64'(e.wt));
    end
  endtask

  task automatic drive_in(input logic [63:0] p, input logic [1:0] ren, input logic [4:0] i0,
                          input logic [4:0] i1, input logic [31:0] v0, input logic [31:0] v1,
                          input logic [1:0] wt);
    in_valid   = 1'b1;
    in_payload = p;
    in_op_ren  = ren;
    in_op_idx  = {i1, i0};
    in_op_val  = {v1, v0};
    in_wait    = wt;
  endtask

  task automatic set_wb(input int j, input logic [4:0] r, input logic [31:0] d);
    wb_wen[j]         = 1'b1;
    wb_wreg[j*5 +: 5]   = r;
    wb_wdata[j*32 +: 32] = d;
  endtask

  task automatic clr_wb();
    wb_wen   = '0;
    wb_wreg  = '0;
    wb_wdata = '0;
  endtask

  logic [1:0] wexp [4];

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_payload = '0; in_op_ren = '0; in_op_idx = '0; in_op_val = '0; in_wait = '0;
    clr_wb();

    // Reset with a valid input present
    drive_in(64'h1111_2222_3333_4444, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 2'd1);
    step();
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    check("t1_op_val", 64'(out_op_val), 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    step();

    // Held entry refreshed by a writeback to its source register
    drive_in(64'hCAFE_0000_0000_0002, 2'b11, 5'd3, 5'd4, 32'hAAAA_0001, 32'hBBBB_0002, 2'd0);
    step();
    in_valid = 1'b0;
    step();
    set_wb(0, 5'd3, 32'h0000_DEAD);
    step();
    clr_wb();
    check("t2_op0_byp", 64'(out_op_val[31:0]), 64'h0000_DEAD);
    step();
    check("t2_op0_hold", 64'(out_op_val[31:0]), 64'h0000_DEAD);
    check("t2_op1", 64'(out_op_val[63:32]), 64'hBBBB_0002);
    check("t2_payload", 64'(out_payload), 64'hCAFE_0000_0000_0002);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // r0 is never bypassed; port 0 wins; non-read slot ignores writebacks
    drive_in(64'h3A, 2'b11, 5'd0, 5'd7, 32'h0000_0AA0, 32'h0000_0BB0, 2'd0);
    set_wb(0, 5'd0, 32'h1234);
    step();
    clr_wb(); in_valid = 1'b0;
    check("t3_r0", 64'(out_op_val[31:0]), 64'h0AA0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drive_in(64'h3B, 2'b01, 5'd5, 5'd6, 32'h0000_0CC0, 32'h0000_0DD0, 2'd0);
    set_wb(0, 5'd5, 32'h11);
    set_wb(1, 5'd5, 32'h22);
    step();
    clr_wb(); in_valid = 1'b0;
    check("t3_prio", 64'(out_op_val[31:0]), 64'h11);
    set_wb(1, 5'd6, 32'h66);
    step();
    clr_wb();
    check("t3_noren", 64'(out_op_val[63:32]), 64'h0DD0);

    // Wait count; the load while issuing also covers issue+accept with no bubble
    out_ready = 1'b1;
    drive_in(64'h4A, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'd0);
    step();
    check("t4_wait0", 64'(out_wait), 64'd0);
    drive_in(64'h4B, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'd3);
    step();
    check("t4_nobubble", 64'(out_payload), 64'h4B);
    out_ready = 1'b0; in_valid = 1'b0;
    wexp[0] = 2'd2; wexp[1] = 2'd1; wexp[2] = 2'd0; wexp[3] = 2'd0;
    check("t4_wait_c0", 64'(out_wait), 64'(wexp[0]));
    for (int c = 1; c < 4; c++) begin
      step();
      check("t4_wait_cnt", 64'(out_wait), 64'(wexp[c]));
    end

    // Flush while stalled drops the same-cycle input
    flush = 1'b1;
    drive_in(64'h5555, 2'b11, 5'd1, 5'd1, 32'h5, 32'h5, 2'd2);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_payload", 64'(out_payload), 64'd0);
    check("t5_op_val", 64'(out_op_val), 64'd0);
    step();

    // Reset mid-stall
    drive_in(64'h6666, 2'b11, 5'd8, 5'd9, 32'h66, 32'h67, 2'd2);
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_stall_valid", 64'(out_valid), 64'd0);
    check("rst_stall_payload", 64'(out_payload), 64'd0);

    // Two back-to-back accepts into a stalled segment
    drive_in(64'h7A, 2'b01, 5'd10, 5'd0, 32'h7A, 32'h0, 2'd0);
    step();
    drive_in(64'h7B, 2'b01, 5'd11, 5'd0, 32'h7B, 32'h0, 2'd0);
    step();
    in_valid = 1'b0;
    check("t6_payload_x", 64'(out_payload), 64'h7A);
`ifdef PSEG_SKID_EN
    check("t6_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    check("t6_valid_y", 64'(out_valid), 64'd1);
    check("t6_payload_y", 64'(out_payload), 64'h7B);
    step();
    check("t6_drained", 64'(out_valid), 64'd0);
`else
    check("t6_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    check("t6_drained", 64'(out_valid), 64'd0);
`endif
    out_ready = 1'b0;

    // Randomised traffic with writebacks to a small register set
    for (int c = 0; c < 200; c++) begin
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 15) == 0);
      in_payload = {$urandom, $urandom};
      in_op_ren  = 2'($urandom_range(0, 3));
      in_op_idx  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      in_op_val  = {$urandom, $urandom};
      in_wait    = 2'($urandom_range(0, 3));
      wb_wen     = 2'($urandom_range(0, 3));
      wb_wreg    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wb_wdata   = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; clr_wb();
    for (int c = 0; c < 3; c++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
